wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and register file for the 5-stage MIPS pipeline.
- Consumes the write-back bundle (regwrite_wb, memtoreg_wb, aluout_wb, readdata_wb, regaddr_wb) from the MEM/WB pipeline register.
- Selects the result, commits it to the 32-entry register file, and serves ID-stage reads with write-through bypass.
- Exports the WB result for EX forwarding, plus a debug read port and a commit counter.

Parameters:
- WIDTH, 32, data word width (matches `WIDTH in defines.v).
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset.
- regwrite_wb  input  1  WB instruction writes a register.
- memtoreg_wb  input  1  1 selects readdata_wb, 0 selects aluout_wb.
- aluout_wb  input  WIDTH  ALU result from MEM/WB.
- readdata_wb  input  WIDTH  load data from MEM/WB.
- regaddr_wb  input  AW  destination register.
- rs_addr_id  input  AW  ID read port A address.
- rt_addr_id  input  AW  ID read port B address.
- rs_data_id  output  WIDTH  read port A data.
- rt_data_id  output  WIDTH  read port B data.
- wb_result  output  WIDTH  selected WB value, for EX forwarding mux.
- wb_valid  output  1  regwrite_wb && regaddr_wb != 0; forwarding qualifier.
- dbg_addr  input  AW  debug/testbench read address.
- dbg_data  output  WIDTH  stored register value, no bypass.
- commit_cnt  output  32  count of cycles with regwrite_wb=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - All NREG registers clear to 0.
  - commit_cnt clears to 0.
  - Combinational outputs follow from the cleared state.
  - Reset dominates any write presented on the same edge.
  - Reset mid-stream discards the in-flight write.
- Result select (combinational): wb_result = memtoreg_wb ? readdata_wb : aluout_wb.
- Commit:
  - On posedge clk with rst=1, regwrite_wb=1 and regaddr_wb!=0: reg[regaddr_wb] <= wb_result.
  - Latency is one edge; the value is visible on dbg_data after that edge.
- Register $0:
  - Never written; always reads 0 on all ports.
  - A write to $0 is silently dropped but still counts in commit_cnt.
- Read ports (combinational, write-through bypass):
  - rs_data_id = 0 if rs_addr_id==0.
  - Else wb_result if wb_valid and rs_addr_id==regaddr_wb.
  - Else reg[rs_addr_id].
  - rt identical with rt_addr_id.
  - This removes the WB->ID hazard without relying on a negedge write.
- Both read ports addressing the same register as the write get the bypass value simultaneously.
- dbg_data = reg[dbg_addr] with no bypass; reads 0 for $0.
- commit_cnt:
  - Increments by 1 on each posedge where regwrite_wb=1.
  - Wraps from 0xFFFFFFFF to 0 with no flag.
- Unknown/X inputs on regwrite_wb while rst=1 are a bench assertion failure.
- No stall input: the MEM/WB register is responsible for bubbling, with regwrite_wb=0 on a bubble.

Decomposition:
- Shared defines.v carries:
  - `WIDTH
  - `NREG
  - `AW
  - `REG_ZERO (5'd0)
- One natural sub-module: regfile_2r1w (storage array with async clear, one write port, two bypassed read ports, one raw debug port).
- wb_regfile instantiates regfile_2r1w and adds:
  - the result mux
  - the wb_valid qualifier
  - the commit counter

Test Plan:
- Reset then idle:
  - All dbg_data reads return 0; commit_cnt=0.
  - Releasing rst with regwrite_wb=1 asserted at the edge commits only from the next edge.
- ALU writeback: regwrite=1, memtoreg=0, aluout=0x1234_5678, regaddr=8.
  - Next edge: dbg_addr=8 gives 0x1234_5678; commit_cnt=1.
- Load writeback with bypass: regwrite=1, memtoreg=1, readdata=0xDEAD_BEEF, aluout=0x1, regaddr=9, rs_addr_id=9, rt_addr_id=9, same cycle.
  - rs_data_id = rt_data_id = 0xDEAD_BEEF before the edge.
  - dbg_data(9) is still the old value until the edge.
- Write to $0: regwrite=1, regaddr=0, aluout=0xFFFF_FFFF.
  - rs_addr_id=0 reads 0; wb_valid=0.
  - dbg(0)=0 after the edge; commit_cnt still increments.
- Async reset mid-operation:
  - Fill r1..r31 with index*0x11.
  - Drop rst between edges while a write to r5 is pending.
  - All registers immediately read 0; r5 is not written; commit_cnt=0.
- Counter wrap:
  - Force commit_cnt to 0xFFFF_FFFE via hierarchical deposit.
  - Two write cycles give 0xFFFF_FFFF then 0x0000_0000.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the MIPS write-back stage and register file.
package wb_regfile_pkg;

   localparam int WIDTH_DEF = 32;   // architectural data word width
   localparam int NREG_DEF  = 32;   // number of architectural registers
   localparam int AW_DEF    = 5;    // register address width, log2(NREG_DEF)
   localparam int CNT_W     = 32;   // commit counter width

   localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;   // hard-wired zero register

   // Write-back bundle as delivered by the MEM/WB pipeline register.
   typedef struct packed {
      logic                 regwrite;
      logic                 memtoreg;
      logic [WIDTH_DEF-1:0] aluout;
      logic [WIDTH_DEF-1:0] readdata;
      logic [AW_DEF-1:0]    regaddr;
   } wb_bundle_t;

   // Write-back result source.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Register storage: async clear, one write port, two read ports with
// write-through bypass, and one raw (unbypassed) debug read port.
module regfile_2r1w
   import wb_regfile_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             i_we,       // already qualified: never set for $0
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr_a,
   input  logic [AW-1:0]    i_raddr_b,
   input  logic [AW-1:0]    i_raddr_dbg,
   output logic [WIDTH-1:0] o_rdata_a,
   output logic [WIDTH-1:0] o_rdata_b,
   output logic [WIDTH-1:0] o_rdata_dbg
);

   logic [WIDTH-1:0] r_mem [NREG];
   logic             w_hit_a;
   logic             w_hit_b;

   // Storage array: cleared asynchronously, committed one edge after the write is presented.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Bypass hits: the register being written this cycle is also being read.
   always_comb begin
      w_hit_a = i_we && (i_raddr_a == i_waddr);
      w_hit_b = i_we && (i_raddr_b == i_waddr);
   end

   // Read ports: $0 forced to zero, then bypass, then stored value.
   always_comb begin
      o_rdata_a = r_mem[i_raddr_a];
      o_rdata_b = r_mem[i_raddr_b];
      if (i_raddr_a == '0) begin
         o_rdata_a = '0;
      end else if (w_hit_a) begin
         o_rdata_a = i_wdata;
      end
      if (i_raddr_b == '0) begin
         o_rdata_b = '0;
      end else if (w_hit_b) begin
         o_rdata_b = i_wdata;
      end
   end

   // Debug port shows committed state only, so a testbench sees exactly what was stored.
   always_comb begin
      o_rdata_dbg = r_mem[i_raddr_dbg];
      if (i_raddr_dbg == '0) begin
         o_rdata_dbg = '0;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects the WB result, commits it to the register
// file, exports it for EX forwarding and counts register-write cycles.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst,          // asynchronous, active-low
   input  logic             regwrite_wb,
   input  logic             memtoreg_wb,
   input  logic [WIDTH-1:0] aluout_wb,
   input  logic [WIDTH-1:0] readdata_wb,
   input  logic [AW-1:0]    regaddr_wb,
   input  logic [AW-1:0]    rs_addr_id,
   input  logic [AW-1:0]    rt_addr_id,
   output logic [WIDTH-1:0] rs_data_id,
   output logic [WIDTH-1:0] rt_data_id,
   output logic [WIDTH-1:0] wb_result,
   output logic             wb_valid,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic [CNT_W-1:0] commit_cnt
);

   wb_src_e          w_src;
   logic [WIDTH-1:0] w_result;
   logic             w_valid;
   logic [CNT_W-1:0] r_commit_cnt;

   // Result select and forwarding qualifier; a write to $0 is never a valid forward.
   always_comb begin
      w_src    = memtoreg_wb ? SRC_MEM : SRC_ALU;
      w_result = (w_src == SRC_MEM) ? readdata_wb : aluout_wb;
      w_valid  = regwrite_wb && (regaddr_wb != '0);
   end

   regfile_2r1w #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW)
   ) u_rf (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_valid),
      .i_waddr     (regaddr_wb),
      .i_wdata     (w_result),
      .i_raddr_a   (rs_addr_id),
      .i_raddr_b   (rt_addr_id),
      .i_raddr_dbg (dbg_addr),
      .o_rdata_a   (rs_data_id),
      .o_rdata_b   (rt_data_id),
      .o_rdata_dbg (dbg_data)
   );

   // Commit counter: every regwrite cycle counts, including dropped writes to $0; wraps silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_commit_cnt <= '0;
      end else if (regwrite_wb) begin
         r_commit_cnt <= r_commit_cnt + 1'b1;
      end
   end

   // Output drive.
   always_comb begin
      wb_result  = w_result;
      wb_valid   = w_valid;
      commit_cnt = r_commit_cnt;
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven vectors with a dbg-port
// scoreboard, plus hand-written reset, reset-release and counter-wrap sequences.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        regwrite_wb;
   logic        memtoreg_wb;
   logic [31:0] aluout_wb;
   logic [31:0] readdata_wb;
   logic [4:0]  regaddr_wb;
   logic [4:0]  rs_addr_id;
   logic [4:0]  rt_addr_id;
   logic [31:0] rs_data_id;
   logic [31:0] rt_data_id;
   logic [31:0] wb_result;
   logic        wb_valid;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] commit_cnt;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ref_regs [32];
   logic [31:0] ref_cnt;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [4:0]  addr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] exp_rs;
      logic [31:0] exp_rt;
      logic [31:0] exp_res;
      logic        exp_valid;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] val;
   } sb_t;

   sb_t sb_q[$];

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .regwrite_wb (regwrite_wb),
      .memtoreg_wb (memtoreg_wb),
      .aluout_wb   (aluout_wb),
      .readdata_wb (readdata_wb),
      .regaddr_wb  (regaddr_wb),
      .rs_addr_id  (rs_addr_id),
      .rt_addr_id  (rt_addr_id),
      .rs_data_id  (rs_data_id),
      .rt_data_id  (rt_data_id),
      .wb_result   (wb_result),
      .wb_valid    (wb_valid),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .commit_cnt  (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // regwrite_wb must never be unknown while out of reset.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         assert (!$isunknown(regwrite_wb)) else $error("regwrite_wb unknown while out of reset");
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic check_all_zero(input string nm);
      for (int a = 0; a < 32; a++) begin
         dbg_addr = a[4:0];
         #1;
         chk(nm, dbg_data, 32'h0);
      end
   endtask

   vec_t vecs [6];
   sb_t  e;
   logic [31:0] new_val;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0,         5'd8,  5'd8,  5'd3,
                  32'h1234_5678, 32'h0000_0033, 32'h1234_5678, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd9,  5'd9,  5'd9,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         5'd0,  5'd0,  5'd8,
                  32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'hAAAA_5555, 32'h0,         5'd8,  5'd8,  5'd9,
                  32'h1234_5678, 32'hDEAD_BEEF, 32'hAAAA_5555, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 5'd31, 5'd31, 5'd8,
                  32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0,         5'd8,  5'd9,  5'd31,
                  32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 1'b1};

      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      ref_cnt = 32'h0;

      // Reset then idle
      rst = 1'b0;
      regwrite_wb = 1'b0; memtoreg_wb = 1'b0;
      aluout_wb = '0; readdata_wb = '0; regaddr_wb = '0;
      rs_addr_id = '0; rt_addr_id = '0; dbg_addr = '0;
      #1;
      check_all_zero("reset_dbg");
      chk("reset_cnt", commit_cnt, 32'h0);

      // Write presented while in reset, reset released just after an edge
      regwrite_wb = 1'b1; aluout_wb = 32'h0000_0033; regaddr_wb = 5'd3; dbg_addr = 5'd3;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("release_dbg3_before", dbg_data, 32'h0);
      chk("release_cnt_before", commit_cnt, 32'h0);
      @(posedge clk); #1;
      chk("release_dbg3_after", dbg_data, 32'h0000_0033);
      chk("release_cnt_after", commit_cnt, 32'h1);
      ref_regs[3] = 32'h0000_0033;
      ref_cnt = 32'h1;

      // Table-driven vectors, committed values checked through the scoreboard
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         regwrite_wb = vecs[i].rw;   memtoreg_wb = vecs[i].m2r;
         aluout_wb   = vecs[i].alu;  readdata_wb = vecs[i].rd;
         regaddr_wb  = vecs[i].addr; rs_addr_id  = vecs[i].rs;
         rt_addr_id  = vecs[i].rt;   dbg_addr    = vecs[i].addr;
         #1;
         chk($sformatf("v%0d_rs", i), rs_data_id, vecs[i].exp_rs);
         chk($sformatf("v%0d_rt", i), rt_data_id, vecs[i].exp_rt);
         chk($sformatf("v%0d_result", i), wb_result, vecs[i].exp_res);
         chk($sformatf("v%0d_valid", i), {31'h0, wb_valid}, {31'h0, vecs[i].exp_valid});
         chk($sformatf("v%0d_dbg_before", i), dbg_data, ref_regs[vecs[i].addr]);
         new_val = ref_regs[vecs[i].addr];
         if (vecs[i].rw && vecs[i].addr != 5'd0) new_val = vecs[i].m2r ? vecs[i].rd : vecs[i].alu;
         sb_q.push_back('{vecs[i].addr, new_val});
         ref_regs[vecs[i].addr] = new_val;
         if (vecs[i].rw) ref_cnt = ref_cnt + 1;
         @(posedge clk); #1;
         e = sb_q.pop_front();
         dbg_addr = e.addr;
         #1;
         chk($sformatf("v%0d_dbg_after", i), dbg_data, e.val);
         chk($sformatf("v%0d_cnt", i), commit_cnt, ref_cnt);
      end

      // Fill r1..r31 with index*0x11
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         regwrite_wb = 1'b1; memtoreg_wb = 1'b0;
         aluout_wb = i * 32'h11; regaddr_wb = i[4:0];
      end
      @(negedge clk);
      regwrite_wb = 1'b0;
      dbg_addr = 5'd17;
      #1;
      chk("fill_dbg17", dbg_data, 32'h0000_0121);
      dbg_addr = 5'd31;
      #1;
      chk("fill_dbg31", dbg_data, 32'h0000_020F);

      // Async reset between edges while a write to r5 is pending
      @(negedge clk);
      regwrite_wb = 1'b1; memtoreg_wb = 1'b0; aluout_wb = 32'h0000_5555; regaddr_wb = 5'd5;
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("midreset_dbg");
      chk("midreset_cnt", commit_cnt, 32'h0);
      regwrite_wb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      dbg_addr = 5'd5;
      #1;
      chk("midreset_r5_not_written", dbg_data, 32'h0);
      chk("midreset_cnt_after", commit_cnt, 32'h0);

      // Counter wrap via deposit
      @(negedge clk);
      force dut.r_commit_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_commit_cnt;
      regwrite_wb = 1'b1; aluout_wb = 32'h0000_0007; regaddr_wb = 5'd7;
      #1;
      chk("wrap_deposit", commit_cnt, 32'hFFFF_FFFE);
      @(posedge clk); #1;
      chk("wrap_first", commit_cnt, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      chk("wrap_second", commit_cnt, 32'h0000_0000);
      regwrite_wb = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
